// File: rtl/trap_sequencer.sv
// Machine-mode trap-entry / MRET-return sequencer driving the CSR trap-write path and fetch redirect.
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_sequencer #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [8:0]      i_exc_req,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic [2:0]      i_irq_pend,
  input  logic [2:0]      i_irq_en,
  input  logic            i_mstatus_mie,
  input  logic [XLEN-1:0] i_irq_pc,
  input  logic            i_mret_req,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_flush,
  output logic            o_stall,
  output logic            o_trap_wr,
  output logic            o_mret_wr,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_epc,
  output logic [XLEN-1:0] o_tval,
  output logic            o_redir_valid,
  input  logic            i_redir_ready,
  output logic [XLEN-1:0] o_redir_pc,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    COMMIT = 2'd2,
    REDIR  = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_is_ret;
  logic            r_flush;
  logic            r_busy;
  logic            r_trap_wr;
  logic            r_mret_wr;
  logic            r_redir_valid;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_redir_pc;

  logic            w_exc_any;
  logic [3:0]      w_exc_code;
  logic [2:0]      w_irq_act;
  logic            w_irq_take;
  logic [3:0]      w_irq_code;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_redir_target;
  logic            w_unused;

  // Lowest set exception bit wins; bit 8 (ecall) maps onto cause 11.
  always_comb begin
    w_exc_any  = |i_exc_req;
    w_exc_code = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (i_exc_req[i]) begin
        w_exc_code = (i == 8) ? 4'd11 : 4'(i);
      end
    end
    w_irq_act  = i_irq_pend & i_irq_en;
    w_irq_take = i_mstatus_mie && (|w_irq_act);
    if (w_irq_act[2]) begin
      w_irq_code = 4'd11;
    end else if (w_irq_act[0]) begin
      w_irq_code = 4'd3;
    end else begin
      w_irq_code = 4'd7;
    end
  end

  assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign w_trap_target = (r_cause[XLEN-1] && (i_mtvec[1:0] == 2'b01))
                       ? w_base + {{(XLEN-6){1'b0}}, r_cause[3:0], 2'b00}
                       : w_base;
`else
  assign w_trap_target = w_base;
`endif

  assign w_redir_target = r_is_ret ? {i_mepc[XLEN-1:2], 2'b00} : w_trap_target;
  assign w_unused       = ^{i_mtvec[1:0], i_mepc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_is_ret      <= 1'b0;
      r_flush       <= 1'b0;
      r_busy        <= 1'b0;
      r_trap_wr     <= 1'b0;
      r_mret_wr     <= 1'b0;
      r_redir_valid <= 1'b0;
      r_cause       <= '0;
      r_epc         <= '0;
      r_tval        <= '0;
      r_redir_pc    <= '0;
    end else begin
      r_trap_wr <= 1'b0;
      r_mret_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_exc_any || i_mret_req || w_irq_take) begin
            r_state <= FLUSH;
            r_flush <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= FLUSH_LOAD;
          end
          if (w_exc_any) begin
            r_is_ret <= 1'b0;
            r_cause  <= {{(XLEN-4){1'b0}}, w_exc_code};
            r_epc    <= i_exc_pc;
            r_tval   <= (w_exc_code == 4'd11) ? '0 : i_exc_tval;
          end else if (i_mret_req) begin
            r_is_ret <= 1'b1;
          end else if (w_irq_take) begin
            r_is_ret <= 1'b0;
            r_cause  <= {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
            r_epc    <= i_irq_pc;
            r_tval   <= '0;
          end
        end
        FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state   <= COMMIT;
            r_flush   <= 1'b0;
            r_trap_wr <= !r_is_ret;
            r_mret_wr <= r_is_ret;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        COMMIT: begin
          r_state       <= REDIR;
          r_redir_pc    <= w_redir_target;
          r_redir_valid <= 1'b1;
        end
        REDIR: begin
          if (i_redir_ready) begin
            r_state       <= IDLE;
            r_redir_valid <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_flush       = r_flush;
  assign o_stall       = r_busy;
  assign o_busy        = r_busy;
  assign o_trap_wr     = r_trap_wr;
  assign o_mret_wr     = r_mret_wr;
  assign o_cause       = r_cause;
  assign o_epc         = r_epc;
  assign o_tval        = r_tval;
  assign o_redir_valid = r_redir_valid;
  assign o_redir_pc    = r_redir_pc;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized traffic
// checked against a behavioural model of trap arbitration and target selection.
module tb_trap_sequencer;

  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  excReq = '0;
  logic [31:0] excPc = '0, excTval = '0, irqPc = '0, mtvec = '0, mepc = '0;
  logic [2:0]  irqPend = '0, irqEn = '0;
  logic        mstatusMie = 1'b0, mretReq = 1'b0, redirReady = 1'b0;
  logic        flush, stall, trapWr, mretWr, redirValid, busy;
  logic [31:0] cause, epc, tval, redirPc;

  int nVec = 0;
  int nErr = 0;

  // Observation record of one transaction
  int          obsFlushFirst, obsFlushLast, obsFlushCnt, obsTrapCnt, obsTrapCyc;
  int          obsMretCnt, obsMretCyc, obsValidCyc, obsHeld;
  logic [31:0] obsCause, obsEpc, obsTval, obsRedirPc;
  bit          obsPcStable, obsStallOk, obsTimeout;
  logic        obsBusyAfter;

  // Model architectural state (last latched trap values)
  logic [31:0] mCause = '0, mEpc = '0, mTval = '0;

  trap_sequencer #(.XLEN(32), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_exc_req(excReq), .i_exc_pc(excPc), .i_exc_tval(excTval),
    .i_irq_pend(irqPend), .i_irq_en(irqEn), .i_mstatus_mie(mstatusMie),
    .i_irq_pc(irqPc), .i_mret_req(mretReq), .i_mtvec(mtvec), .i_mepc(mepc),
    .o_flush(flush), .o_stall(stall), .o_trap_wr(trapWr), .o_mret_wr(mretWr),
    .o_cause(cause), .o_epc(epc), .o_tval(tval),
    .o_redir_valid(redirValid), .i_redir_ready(redirReady),
    .o_redir_pc(redirPc), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit irq_line(int code);
    case (code)
      11:      return irqPend[2] & irqEn[2];
      7:       return irqPend[1] & irqEn[1];
      default: return irqPend[0] & irqEn[0];
    endcase
  endfunction

  // kind: 0 = nothing taken, 1 = trap, 2 = MRET
  task automatic predict(output int kind, output logic [31:0] c, output logic [31:0] e,
                         output logic [31:0] t, output logic [31:0] pc);
    int codes[3] = '{11, 3, 7};
    kind = 0; c = mCause; e = mEpc; t = mTval; pc = 0;
    if (excReq != 0) begin
      for (int i = 0; i < 9; i++) begin
        if (excReq[i]) begin
          kind = 1;
          c = (i == 8) ? 11 : i;
          e = excPc;
          t = (i == 8) ? 0 : excTval;
          break;
        end
      end
    end else if (mretReq) begin
      kind = 2;
    end else if (mstatusMie) begin
      for (int k = 0; k < 3; k++) begin
        if (irq_line(codes[k])) begin
          kind = 1;
          c = 32'h8000_0000 + codes[k];
          e = irqPc;
          t = 0;
          break;
        end
      end
    end
    if (kind == 2) begin
      pc = mepc & ~32'd3;
    end else begin
      pc = mtvec & ~32'd3;
`ifdef TRAP_VECTORED_EN
      if (c[31] && mtvec[1:0] == 2'b01) pc = pc + 4 * (c & 32'hF);
`endif
    end
  endtask

  // Watches one transaction after the request is presented; requests drop after cycle 1.
  task automatic observe(input int delay);
    obsFlushFirst = 0; obsFlushLast = 0; obsFlushCnt = 0; obsTrapCnt = 0; obsTrapCyc = 0;
    obsMretCnt = 0; obsMretCyc = 0; obsValidCyc = 0; obsHeld = 0;
    obsCause = 'x; obsEpc = 'x; obsTval = 'x; obsRedirPc = 'x; obsBusyAfter = 1'bx;
    obsPcStable = 1; obsStallOk = 1; obsTimeout = 1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin excReq = '0; mretReq = 1'b0; irqPend = '0; end
      redirReady = (obsValidCyc > 0) && (cyc >= obsValidCyc + delay);
      @(negedge clk);
      if (flush) begin
        obsFlushCnt++;
        if (obsFlushFirst == 0) obsFlushFirst = cyc;
        obsFlushLast = cyc;
      end
      if (trapWr) begin
        obsTrapCnt++; obsTrapCyc = cyc;
        obsCause = cause; obsEpc = epc; obsTval = tval;
      end
      if (mretWr) begin
        obsMretCnt++; obsMretCyc = cyc;
        obsCause = cause; obsEpc = epc; obsTval = tval;
      end
      if (stall !== busy) obsStallOk = 0;
      if (redirValid) begin
        obsHeld++;
        if (obsValidCyc == 0) begin
          obsValidCyc = cyc; obsRedirPc = redirPc;
        end else if (redirPc !== obsRedirPc) begin
          obsPcStable = 0;
        end
        if (redirReady) begin
          @(posedge clk); #1 redirReady = 1'b0;
          @(negedge clk);
          obsBusyAfter = busy;
          obsTimeout = 0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nVec++;
    if ({flush, stall, trapWr, mretWr, redirValid, busy} !== 6'b0) begin
      nErr++; $display("[TB] FAIL reset_ctrl got=%b want=000000", {flush, stall, trapWr, mretWr, redirValid, busy});
    end
    nVec++;
    if ({cause, epc, tval, redirPc} !== 128'b0) begin
      nErr++; $display("[TB] FAIL reset_data got=%h/%h/%h/%h want=0", cause, epc, tval, redirPc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    mCause = 0; mEpc = 0; mTval = 0;
  endtask

  task automatic test_exception();
    @(posedge clk); #1;
    excReq = 9'h004; excPc = 32'h100; excTval = 32'hDEADBEEF; mtvec = 32'h80000001;
    observe(1);
    nVec++;
    if (obsFlushFirst != 1 || obsFlushLast != F || obsFlushCnt != F) begin
      nErr++; $display("[TB] FAIL exc_flush got=%0d..%0d n=%0d want=1..%0d", obsFlushFirst, obsFlushLast, obsFlushCnt, F);
    end
    nVec++;
    if (obsTrapCnt != 1 || obsTrapCyc != F + 1 || obsMretCnt != 0) begin
      nErr++; $display("[TB] FAIL exc_strobe got=%0d@%0d mret=%0d want=1@%0d", obsTrapCnt, obsTrapCyc, obsMretCnt, F + 1);
    end
    nVec++;
    if (obsCause !== 32'd2 || obsEpc !== 32'h100 || obsTval !== 32'hDEADBEEF) begin
      nErr++; $display("[TB] FAIL exc_csr got=%h/%h/%h want=2/100/deadbeef", obsCause, obsEpc, obsTval);
    end
    nVec++;
    if (obsRedirPc !== 32'h80000000 || obsValidCyc != F + 2) begin
      nErr++; $display("[TB] FAIL exc_redir got=%h@%0d want=80000000@%0d", obsRedirPc, obsValidCyc, F + 2);
    end
    mCause = 2; mEpc = 32'h100; mTval = 32'hDEADBEEF;
  endtask

  task automatic test_interrupt();
    logic [31:0] wantPc;
`ifdef TRAP_VECTORED_EN
    wantPc = 32'h8000002C;
`else
    wantPc = 32'h80000000;
`endif
    @(posedge clk); #1;
    irqPend = 3'b111; irqEn = 3'b111; mstatusMie = 1'b1; irqPc = 32'h40; mtvec = 32'h80000001;
    observe(2);
    nVec++;
    if (obsCause !== 32'h8000000B || obsEpc !== 32'h40 || obsTval !== 32'h0 || obsTrapCnt != 1) begin
      nErr++; $display("[TB] FAIL irq_csr got=%h/%h/%h n=%0d want=8000000b/40/0 n=1", obsCause, obsEpc, obsTval, obsTrapCnt);
    end
    nVec++;
    if (obsRedirPc !== wantPc || obsBusyAfter !== 1'b0) begin
      nErr++; $display("[TB] FAIL irq_redir got=%h busy=%b want=%h busy=0", obsRedirPc, obsBusyAfter, wantPc);
    end
    mCause = 32'h8000000B; mEpc = 32'h40; mTval = 0;
    mstatusMie = 1'b0; irqEn = '0;
  endtask

  task automatic test_masked();
    bit seen = 0;
    @(posedge clk); #1;
    irqPend = 3'b100; irqEn = 3'b100; mstatusMie = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || flush || trapWr) seen = 1;
    end
    nVec++;
    if (seen) begin
      nErr++; $display("[TB] FAIL irq_masked got=activity want=idle");
    end
    @(posedge clk); #1 irqPend = '0; irqEn = '0;
  endtask

  task automatic test_exc_mret();
    @(posedge clk); #1;
    excReq = 9'h100; mretReq = 1'b1; excPc = 32'h300; excTval = 32'h1234; mtvec = 32'h1000;
    observe(1);
    nVec++;
    if (obsCause !== 32'd11 || obsTval !== 32'h0 || obsEpc !== 32'h300) begin
      nErr++; $display("[TB] FAIL ecall_csr got=%h/%h/%h want=b/300/0", obsCause, obsEpc, obsTval);
    end
    nVec++;
    if (obsTrapCnt != 1 || obsMretCnt != 0) begin
      nErr++; $display("[TB] FAIL ecall_strobes got trap=%0d mret=%0d want=1/0", obsTrapCnt, obsMretCnt);
    end
    mCause = 11; mEpc = 32'h300; mTval = 0;
  endtask

  task automatic test_mret_backpressure();
    @(posedge clk); #1;
    mretReq = 1'b1; mepc = 32'h207;
    observe(5);
    nVec++;
    if (obsMretCnt != 1 || obsTrapCnt != 0 || obsMretCyc != F + 1) begin
      nErr++; $display("[TB] FAIL mret_strobe got=%0d@%0d trap=%0d want=1@%0d", obsMretCnt, obsMretCyc, obsTrapCnt, F + 1);
    end
    nVec++;
    if (obsRedirPc !== 32'h204 || !obsPcStable || obsHeld != 6) begin
      nErr++; $display("[TB] FAIL mret_redir got=%h stable=%0d held=%0d want=204 1 6", obsRedirPc, obsPcStable, obsHeld);
    end
    nVec++;
    if (obsBusyAfter !== 1'b0 || obsCause !== mCause || obsEpc !== mEpc) begin
      nErr++; $display("[TB] FAIL mret_after got busy=%b cause=%h epc=%h want=0 %h %h", obsBusyAfter, obsCause, obsEpc, mCause, mEpc);
    end
  endtask

  task automatic test_reset_midflush();
    bit seen = 0;
    @(posedge clk); #1;
    excReq = 9'h001; excPc = 32'h500; excTval = 32'h77;
    @(posedge clk); #1;
    excReq = '0;
    nVec++;
    if (flush !== 1'b1) begin
      nErr++; $display("[TB] FAIL rst_pre_flush got=%b want=1", flush);
    end
    rst_n = 1'b0;
    #1;
    nVec++;
    if ({flush, stall, trapWr, mretWr, redirValid, busy} !== 6'b0 || {cause, epc, tval} !== 96'b0) begin
      nErr++; $display("[TB] FAIL rst_mid got ctrl=%b cause=%h epc=%h want=0", {flush, stall, trapWr, mretWr, redirValid, busy}, cause, epc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    mCause = 0; mEpc = 0; mTval = 0;
    repeat (10) begin
      @(negedge clk);
      if (trapWr || redirValid || busy) seen = 1;
    end
    nVec++;
    if (seen) begin
      nErr++; $display("[TB] FAIL rst_quiet got=activity want=idle");
    end
  endtask

  task automatic test_random();
    int kind, dly;
    logic [31:0] c, e, t, pc;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      excReq     = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h0;
      mretReq    = ($urandom_range(0, 2) == 0);
      irqPend    = 3'($urandom);
      irqEn      = 3'($urandom);
      mstatusMie = 1'($urandom);
      excPc = $urandom; excTval = $urandom; irqPc = $urandom; mepc = $urandom;
      mtvec = {$urandom} & ~32'd3;
      mtvec = mtvec | 32'($urandom_range(0, 1));
      predict(kind, c, e, t, pc);
      if (kind == 0) begin
        repeat (3) @(negedge clk);
        nVec++;
        if (busy !== 1'b0) begin
          nErr++; $display("[TB] FAIL rnd%0d_idle got busy=%b want=0", n, busy);
        end
        @(posedge clk); #1 irqPend = '0;
        continue;
      end
      dly = $urandom_range(1, 3);
      observe(dly);
      nVec++;
      if (obsTimeout || obsBusyAfter !== 1'b0 || !obsStallOk || !obsPcStable || obsHeld != dly + 1) begin
        nErr++; $display("[TB] FAIL rnd%0d_hs got to=%0d busy=%b stall=%0d stable=%0d held=%0d want held=%0d", n, obsTimeout, obsBusyAfter, obsStallOk, obsPcStable, obsHeld, dly + 1);
      end
      nVec++;
      if (obsFlushFirst != 1 || obsFlushCnt != F || obsValidCyc != F + 2 ||
          obsTrapCnt != (kind == 1 ? 1 : 0) || obsMretCnt != (kind == 2 ? 1 : 0)) begin
        nErr++; $display("[TB] FAIL rnd%0d_timing got fl=%0d/%0d trap=%0d mret=%0d v=%0d kind=%0d", n, obsFlushFirst, obsFlushCnt, obsTrapCnt, obsMretCnt, obsValidCyc, kind);
      end
      nVec++;
      if (obsCause !== c || obsEpc !== e || obsTval !== t || obsRedirPc !== pc) begin
        nErr++; $display("[TB] FAIL rnd%0d_values got=%h/%h/%h/%h want=%h/%h/%h/%h", n, obsCause, obsEpc, obsTval, obsRedirPc, c, e, t, pc);
      end
      mCause = c; mEpc = e; mTval = t;
      if (obsTimeout) break;
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_masked();
    test_exc_mret();
    test_mret_backpressure();
    test_reset_midflush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
